// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate-select encoding, ID-stage state
// and the control bundle produced by the decoder.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // The immediate generator decodes this same encoding.
  typedef enum logic [2:0] {
    IMM_S = 3'b000,
    IMM_B = 3'b001,
    IMM_J = 3'b010,
    IMM_I = 3'b011,
    IMM_U = 3'b110
  } imm_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_HAZARD = 2'd2
  } id_state_e;

  typedef struct packed {
    imm_sel_e imm_sel;
    logic     rd_wren;
    logic     mem_rden;
    logic     mem_wren;
    logic     illegal;
    logic     uses_rs1;
    logic     uses_rs2;
  } dec_ctrl_t;

endpackage

// File: rtl/id_stage_ctrl_if.sv
// IF/EX-facing signal bundle of the decode-stage controller.
// Handshake: a transfer happens on a cycle where valid and ready are both high; valid
// never depends on ready of the same channel, and i_flush cancels any IF transfer.
interface id_stage_ctrl_if #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
);
  logic                   i_if_valid;
  logic [XLEN-1:0]        i_if_instr;
  logic [XLEN-1:0]        i_if_pc;
  logic                   o_if_ready;
  logic                   o_ex_valid;
  logic                   i_ex_ready;
  logic [XLEN-1:0]        o_ex_instr;
  logic [XLEN-1:0]        o_ex_pc;
  logic [2:0]             o_imm_sel;
  logic                   o_rd_wren;
  logic                   o_mem_rden;
  logic                   o_mem_wren;
  logic                   o_illegal;
  logic [4:0]             i_ex_rd;
  logic                   i_ex_is_load;
  logic                   i_flush;
  logic [STALL_CNT_W-1:0] o_stall_cnt;

  modport master (
    output i_if_valid, i_if_instr, i_if_pc, i_ex_ready, i_ex_rd, i_ex_is_load, i_flush,
    input  o_if_ready, o_ex_valid, o_ex_instr, o_ex_pc, o_imm_sel, o_rd_wren,
           o_mem_rden, o_mem_wren, o_illegal, o_stall_cnt
  );

  modport slave (
    input  i_if_valid, i_if_instr, i_if_pc, i_ex_ready, i_ex_rd, i_ex_is_load, i_flush,
    output o_if_ready, o_ex_valid, o_ex_instr, o_ex_pc, o_imm_sel, o_rd_wren,
           o_mem_rden, o_mem_wren, o_illegal, o_stall_cnt
  );
endinterface

// File: rtl/id_decode.sv
// Combinational opcode decoder: immediate select, control enables and which source
// registers the instruction actually reads.
module id_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [4:0] rd_i,
  output dec_ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o          = '0;
    ctrl_o.imm_sel  = IMM_I;
    ctrl_o.uses_rs1 = 1'b1;
    case (opcode_i)
      OPC_LOAD: begin
        ctrl_o.rd_wren  = 1'b1;
        ctrl_o.mem_rden = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.imm_sel  = IMM_S;
        ctrl_o.mem_wren = 1'b1;
        ctrl_o.uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: ctrl_o.rd_wren = 1'b1;
      OPC_OP: begin
        ctrl_o.rd_wren  = 1'b1;
        ctrl_o.uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.imm_sel  = IMM_B;
        ctrl_o.uses_rs2 = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.imm_sel  = IMM_J;
        ctrl_o.rd_wren  = 1'b1;
        ctrl_o.uses_rs1 = 1'b0;
      end
      OPC_JALR: ctrl_o.rd_wren = 1'b1;
      OPC_LUI, OPC_AUIPC: begin
        ctrl_o.imm_sel  = IMM_U;
        ctrl_o.rd_wren  = 1'b1;
        ctrl_o.uses_rs1 = 1'b0;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    // x0 is hardwired; never request a write to it.
    if (rd_i == 5'd0) ctrl_o.rd_wren = 1'b0;
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage pipeline register between IF and EX: valid/ready on both sides,
// one bubble per load-use hazard, flush from EX, saturating hazard counter.
module id_stage_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  id_stage_ctrl_if.slave  bus,
  output id_state_e       o_state_dbg
);

  id_state_e              state_q, state_d;
  logic [XLEN-1:0]        instr_q, instr_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  dec_ctrl_t  dec;
  logic       id_valid;
  logic       hazard;
  logic       ex_valid;
  logic       fire_out;
  logic       if_ready;
  logic       fire_in;
  logic [4:0] rs1, rs2;

  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];

  id_decode u_decode (
    .opcode_i (instr_q[6:0]),
    .rd_i     (instr_q[11:7]),
    .ctrl_o   (dec)
  );

  assign id_valid = (state_q != ST_EMPTY);
  assign hazard   = id_valid && bus.i_ex_is_load && (bus.i_ex_rd != 5'd0) &&
                    ((dec.uses_rs1 && (rs1 == bus.i_ex_rd)) ||
                     (dec.uses_rs2 && (rs2 == bus.i_ex_rd)));
  assign ex_valid = id_valid && !hazard && !bus.i_flush;
  assign fire_out = ex_valid && bus.i_ex_ready;
  assign if_ready = !id_valid || fire_out || bus.i_flush;
  assign fire_in  = bus.i_if_valid && if_ready && !bus.i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_EMPTY;
      instr_q     <= XLEN'(NOP_INSTR);
      pc_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The stored state is only EMPTY/FULL; HAZARD is a combinational view of FULL.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.i_flush) begin
      state_d = ST_EMPTY;
    end else if (fire_in) begin
      state_d = ST_FULL;
      instr_d = bus.i_if_instr;
      pc_d    = bus.i_if_pc;
    end else if (fire_out) begin
      state_d = ST_EMPTY;
    end
    if (hazard && !bus.i_flush && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_comb begin
    bus.o_ex_valid  = ex_valid;
    bus.o_if_ready  = if_ready;
    bus.o_ex_instr  = instr_q;
    bus.o_ex_pc     = pc_q;
    bus.o_imm_sel   = dec.imm_sel;
    bus.o_rd_wren   = dec.rd_wren;
    bus.o_mem_rden  = dec.mem_rden;
    bus.o_mem_wren  = dec.mem_wren;
    bus.o_illegal   = dec.illegal;
    bus.o_stall_cnt = stall_cnt_q;
    if (!id_valid)   o_state_dbg = ST_EMPTY;
    else if (hazard) o_state_dbg = ST_HAZARD;
    else             o_state_dbg = ST_FULL;
  end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Scoreboard bench for id_stage_ctrl: directed scenarios plus random traffic against
// a queue-based model of the decode-stage register, and a narrow-counter instance.
module tb_id_stage_ctrl;
  import rv_pkg::*;

  localparam int W = 64;

  logic      clk;
  logic      rst;
  id_state_e state_dbg;
  id_state_e state_dbg_s;

  id_stage_ctrl_if #(.XLEN(32), .STALL_CNT_W(16)) bus ();
  id_stage_ctrl_if #(.XLEN(32), .STALL_CNT_W(3))  bus_s ();

  id_stage_ctrl #(.XLEN(32), .STALL_CNT_W(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_state_dbg (state_dbg)
  );

  id_stage_ctrl #(.XLEN(32), .STALL_CNT_W(3)) dut_s (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus_s),
    .o_state_dbg (state_dbg_s)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_stall = '0;
  logic         mon_en = 1'b0;
  logic [31:0]  pc_ctr = 32'h100;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  // Reference decode table: {illegal, mem_wren, mem_rden, rd_wren, imm_sel[2:0]}
  function automatic logic [6:0] ref_dec(input logic [31:0] ins);
    logic [6:0] r;
    case (ins[6:0])
      7'b0000011: r = {4'b0011, 3'b011};
      7'b0100011: r = {4'b0100, 3'b000};
      7'b0010011: r = {4'b0001, 3'b011};
      7'b0110011: r = {4'b0001, 3'b011};
      7'b1100011: r = {4'b0000, 3'b001};
      7'b1101111: r = {4'b0001, 3'b010};
      7'b1100111: r = {4'b0001, 3'b011};
      7'b0110111: r = {4'b0001, 3'b110};
      7'b0010111: r = {4'b0001, 3'b110};
      default:    r = {4'b1000, 3'b011};
    endcase
    if (ins[11:7] == 5'd0) r[3] = 1'b0;
    return r;
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_stall = '0;
    end else if (mon_en) begin
      automatic bit          held = (exp_q.size() > 0);
      automatic logic [63:0] f    = held ? exp_q[0] : 64'd0;
      automatic logic [31:0] ins  = f[31:0];
      automatic logic [6:0]  d    = ref_dec(ins);
      automatic bit hz = held && bus.i_ex_is_load && (bus.i_ex_rd != 5'd0) &&
                         ((reads_rs1(ins[6:0]) && ins[19:15] == bus.i_ex_rd) ||
                          (reads_rs2(ins[6:0]) && ins[24:20] == bus.i_ex_rd));
      automatic bit e_v  = held && !hz && !bus.i_flush;
      automatic bit e_fo = e_v && bus.i_ex_ready;
      automatic bit e_ir = !held || e_fo || bus.i_flush;
      automatic id_state_e e_st = !held ? ST_EMPTY : (hz ? ST_HAZARD : ST_FULL);

      chk("ex_valid", 64'(bus.o_ex_valid), 64'(e_v));
      chk("if_ready", 64'(bus.o_if_ready), 64'(e_ir));
      chk("stall_cnt", 64'(bus.o_stall_cnt), 64'(exp_stall));
      chk("state_dbg", 64'(state_dbg), 64'(e_st));
      if (held) begin
        chk("ex_instr", 64'(bus.o_ex_instr), 64'(ins));
        chk("ex_pc", 64'(bus.o_ex_pc), 64'(f[63:32]));
      end
      if (e_v) begin
        chk("imm_sel", 64'(bus.o_imm_sel), 64'(d[2:0]));
        chk("rd_wren", 64'(bus.o_rd_wren), 64'(d[3]));
        chk("mem_rden", 64'(bus.o_mem_rden), 64'(d[4]));
        chk("mem_wren", 64'(bus.o_mem_wren), 64'(d[5]));
        chk("illegal", 64'(bus.o_illegal), 64'(d[6]));
      end

      if (bus.i_flush) exp_q.delete();
      else begin
        if (e_fo) void'(exp_q.pop_front());
        if (bus.i_if_valid && e_ir) exp_q.push_back({bus.i_if_pc, bus.i_if_instr});
      end
      if (hz && !bus.i_flush && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [4:0] exrd,
                     input logic ld, input logic rdy, input logic fl);
    bus.i_if_valid   = v;
    bus.i_if_instr   = ins;
    bus.i_if_pc      = pc_ctr;
    bus.i_ex_rd      = exrd;
    bus.i_ex_is_load = ld;
    bus.i_ex_ready   = rdy;
    bus.i_flush      = fl;
    pc_ctr           = pc_ctr + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_s();
    bus_s.i_if_valid   = 1'b0;
    bus_s.i_if_instr   = 32'h0;
    bus_s.i_if_pc      = 32'h0;
    bus_s.i_ex_rd      = 5'd0;
    bus_s.i_ex_is_load = 1'b0;
    bus_s.i_ex_ready   = 1'b1;
    bus_s.i_flush      = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] ops [12];
  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'h7F, 7'h00, 7'b0001111};
    rst = 1'b1;
    idle_s();
    bus.i_if_valid = 1'b0; bus.i_if_instr = '0; bus.i_if_pc = '0; bus.i_ex_rd = '0;
    bus.i_ex_is_load = 1'b0; bus.i_ex_ready = 1'b1; bus.i_flush = 1'b0;
    #2;
    chk("rst_ex_valid", 64'(bus.o_ex_valid), 64'd0);
    chk("rst_if_ready", 64'(bus.o_if_ready), 64'd1);
    chk("rst_imm_sel", 64'(bus.o_imm_sel), 64'd3);
    chk("rst_enables", 64'({bus.o_rd_wren, bus.o_mem_rden, bus.o_mem_wren}), 64'd0);
    chk("rst_illegal", 64'(bus.o_illegal), 64'd0);
    chk("rst_instr", 64'(bus.o_ex_instr), 64'h13);
    chk("rst_pc", 64'(bus.o_ex_pc), 64'd0);
    chk("rst_stall", 64'(bus.o_stall_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // ADDI stream, no back-pressure
    repeat (4) cyc(1, 32'h00500093, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // load-use: ADD x3,x2,x1 behind LW x2 -> one bubble
    cyc(1, mk(7'b0110011, 3, 2, 1), 0, 0, 1, 0);
    cyc(1, 32'h00500093, 2, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    // load rd=x0, and LUI not reading rs1 -> no bubble
    cyc(1, mk(7'b0110011, 3, 0, 0), 0, 0, 1, 0);
    cyc(1, mk(7'b0110111, 3, 2, 2), 0, 1, 1, 0);
    cyc(0, 0, 2, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // back-pressure for three cycles, then release with a new offer
    cyc(1, mk(7'b0010011, 4, 1, 0), 0, 0, 1, 0);
    repeat (3) cyc(1, mk(7'b0010011, 5, 1, 0), 0, 0, 0, 0);
    cyc(1, mk(7'b0010011, 5, 1, 0), 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // flush together with an IF offer and a load-use hazard
    cyc(1, mk(7'b0110011, 3, 2, 1), 0, 0, 1, 0);
    cyc(1, mk(7'b0010011, 6, 0, 0), 2, 1, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);

    // opcode sweep including undefined encodings
    foreach (ops[i]) cyc(1, mk(ops[i], 5'd5, 5'd1, 5'd2), 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      automatic logic [31:0] ins = mk(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)),
                                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      if ($urandom_range(0, 15) == 0) ins = $urandom;
      cyc(($urandom_range(0, 3) != 0), ins, 5'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0));
    end

    // asynchronous reset while an instruction is held
    cyc(1, 32'h00500093, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hold_before_rst", 64'(bus.o_ex_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.o_ex_valid), 64'd0);
    chk("async_rst_state", 64'(state_dbg), 64'(ST_EMPTY));
    chk("async_rst_instr", 64'(bus.o_ex_instr), 64'h13);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 1, 0);

    // saturating counter on the 3-bit instance
    bus_s.i_if_valid = 1'b1;
    bus_s.i_if_instr = mk(7'b0110011, 3, 2, 1);
    @(posedge clk); #1;
    bus_s.i_if_valid   = 1'b0;
    bus_s.i_ex_is_load = 1'b1;
    bus_s.i_ex_rd      = 5'd2;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk("sat_cnt", 64'(bus_s.o_stall_cnt), 64'((k > 7) ? 7 : k));
      chk("sat_valid", 64'(bus_s.o_ex_valid), 64'd0);
    end
    idle_s();
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
Decode-stage controller for the pipelined RV32I core. It holds the instruction between the IF and EX stages using valid/ready handshakes on both sides. It decodes the opcode into the immediate-generator select and the basic control enables. It also detects load-use hazards, inserting one bubble per hazard, and squashes its contents on a branch/jump flush from EX.

Parameters:
XLEN, 32, instruction/PC width
STALL_CNT_W, 16, width of saturating load-use stall counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_if_valid  in  1  IF offers instruction
i_if_instr  in  XLEN  fetched instruction
i_if_pc  in  XLEN  PC of fetched instruction
o_if_ready  out  1  ID accepts this cycle
o_ex_valid  out  1  ID presents a valid instruction to EX
i_ex_ready  in  1  EX accepts this cycle
o_ex_instr  out  XLEN  held instruction
o_ex_pc  out  XLEN  held PC
o_imm_sel  out  3  immediate select for the immediate generator
o_rd_wren  out  1  instruction writes rd
o_mem_rden  out  1  load
o_mem_wren  out  1  store
o_illegal  out  1  unrecognised opcode (qualified by o_ex_valid)
i_ex_rd  in  5  rd of the instruction currently in EX
i_ex_is_load  in  1  EX instruction is a valid load
i_flush  in  1  branch/jump redirect from EX
o_stall_cnt  out  STALL_CNT_W  saturating count of load-use bubbles

Behaviour:
- One clock (i_clk); reset is asynchronous and active-high (i_rst).
- Reset values: id_valid=0, instr=32'h0000_0013 (NOP), pc=0, stall_cnt=0.
  - Therefore o_ex_valid=0, o_if_ready=1, o_imm_sel=3'b011, all enables 0, o_illegal=0.
- Reset mid-transfer discards the held instruction.
- State machine:
  - EMPTY: id_valid=0.
  - FULL: id_valid=1, no hazard.
  - HAZARD: id_valid=1, load-use active. HAZARD is combinationally derived from FULL.
- Hazard rule:
  - hazard = id_valid & i_ex_is_load & (i_ex_rd != 0) & ((uses_rs1 & rs1==i_ex_rd) | (uses_rs2 & rs2==i_ex_rd)).
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH.
- Outputs and handshakes:
  - o_ex_valid = id_valid & ~hazard & ~i_flush.
  - fire_out = o_ex_valid & i_ex_ready.
  - o_if_ready = ~id_valid | fire_out | i_flush.
  - fire_in = i_if_valid & o_if_ready & ~i_flush.
- Register update priority, highest first:
  1. i_flush: id_valid←0. The IF offer is dropped that cycle; IF must resend from the new PC.
  2. fire_in: load instr/pc, id_valid←1 (fill from empty and back-to-back replace both take zero bubbles).
  3. fire_out without fire_in: id_valid←0.
  4. Otherwise hold instr/pc.
- Hazard timing:
  - Each hazard cycle increments stall_cnt; it saturates at all-ones and does not wrap.
  - A load-use pair costs exactly one bubble, because EX advances to a non-load or a bubble.
  - Hazard and i_flush in the same cycle: the flush wins and stall_cnt is not incremented.
- Decode of instr[6:0] to imm_sel / rd_wren / mem_rden / mem_wren:
  - LOAD 0000011 → I(011), 1, 1, 0
  - STORE 0100011 → S(000), 0, 0, 1
  - OP-IMM 0010011 → I, 1, 0, 0
  - OP 0110011 → I, 1, 0, 0
  - BRANCH 1100011 → B(001), 0, 0, 0
  - JAL 1101111 → J(010), 1, 0, 0
  - JALR 1100111 → I, 1, 0, 0
  - LUI 0110111 → U(110), 1, 0, 0
  - AUIPC 0010111 → U, 1, 0, 0
  - Other opcodes: I, all enables 0, o_illegal=1.
- Decode outputs are combinational from the registered instruction; they carry zero latency relative to o_ex_instr.
- rd_wren is forced 0 when rd==0.

Decomposition:
- Package rv_pkg:
  - Opcode localparams.
  - imm_sel enum: IMM_S=3'b000, IMM_B=3'b001, IMM_J=3'b010, IMM_I=3'b011, IMM_U=3'b110. The immediate generator shares this enum.
  - NOP constant.
- One sub-module, id_decode: purely combinational opcode→controls, uses_rs1 and uses_rs2.
- The top level holds the pipeline register, handshake, hazard and counter logic.

Test Plan:
- Reset then stream ADDI x1,x0,5 (0x00500093) with i_ex_ready=1 → o_ex_valid next cycle; imm_sel=011, rd_wren=1; o_if_ready stays 1 with no bubbles.
- Hold LW x2,0(x1) in EX (i_ex_is_load=1, i_ex_rd=2), ID=ADD x3,x2,x1 → exactly one cycle with o_ex_valid=0 and o_if_ready=0; o_stall_cnt 0→1; ADD issues the following cycle.
- Same case but i_ex_rd=0, or ID=LUI x3 (rs1 unused) → no bubble, stall_cnt unchanged.
- i_ex_ready=0 for 3 cycles with ID full → instr/pc stable, o_if_ready=0; on release, next IF instruction is accepted the same cycle.
- i_flush asserted together with i_if_valid and a hazard → next cycle o_ex_valid=0, id_valid=0, stall_cnt unchanged, IF instruction not captured.
- Opcode sweep including 0x7F and 0x00 → the decode table above is matched; o_illegal=1 only for unlisted opcodes. Assert i_rst mid-hold → o_ex_valid drops immediately (async).
